acs_sched_ctrl: RTL and testbench

Symbol-level sequencer for a bank of multi-h ACS units. It generates the four-slot serial schedule (slot index and rotator angle) that each ACS uses to time-share its single rotator across four branch metrics. It keeps the per-symbol phase tilt and symbol parity. It also arbitrates metric-normalization requests from all ACS units into one bank-wide, symbol-aligned normalize pulse.

---
 rtl/acs_sched_ctrl_if.sv | 28 ++
 rtl/acs_sched_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_acs_sched_ctrl.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/acs_sched_ctrl_if.sv
// Bus between the ACS bank sequencer and its environment.
// It carries the symbol strobes, the normalize requests and all scheduler outputs.
interface acs_sched_ctrl_if #(
    parameter int unsigned NUM_ACS = 8
);
    logic               enable;
    logic               symEn;
    logic               symEnEven;
    logic [NUM_ACS-1:0] normReq;
    logic [1:0]         slot;
    logic               slotValid;
    logic [4:0]         angle;
    logic [4:0]         tilt;
    logic               parity;
    logic               normalize;
    logic [7:0]         normCount;
    logic               overrun;

    modport master (
        output enable, symEn, symEnEven, normReq,
        input  slot, slotValid, angle, tilt, parity, normalize, normCount, overrun
    );

    modport slave (
        input  enable, symEn, symEnEven, normReq,
        output slot, slotValid, angle, tilt, parity, normalize, normCount, overrun
    );
endinterface

// File: rtl/acs_sched_ctrl.sv
// Symbol-level sequencer for a bank of multi-h ACS units. It generates the
// four-slot rotator schedule and keeps the per-symbol tilt and parity. It also
// merges the per-unit normalize requests into one symbol-aligned normalize pulse.
module acs_sched_ctrl #(
    parameter int unsigned NUM_ACS      = 8,
    parameter int unsigned TILT_STEP    = 1,
    parameter int unsigned HOLDOFF_SYMS = 2,
    parameter int unsigned ROT_45_0     = 0,
    parameter int unsigned ROT_45_1     = 0,
    parameter int unsigned ROT_45_2     = 0,
    parameter int unsigned ROT_45_3     = 0,
    parameter int unsigned ROT_54_0     = 0,
    parameter int unsigned ROT_54_1     = 0,
    parameter int unsigned ROT_54_2     = 0,
    parameter int unsigned ROT_54_3     = 0
) (
    input logic              clk,
    input logic              reset,
    acs_sched_ctrl_if.slave  bus
);

    localparam logic [4:0] TiltInc  = 5'(TILT_STEP % 32);
    localparam logic [3:0] HoldLoad = 4'(HOLDOFF_SYMS);

    typedef enum logic [1:0] {StIdle, StArmed, StIssue, StHoldoff} norm_state_e;

    // Odd parity (0) uses the 4/5 table, even parity (1) uses the 5/4 table.
    function automatic logic [3:0] rot_sel(input logic par, input logic [1:0] s);
        logic [3:0] r;
        r = '0;
        if (par) begin
            case (s)
                2'd0:    r = 4'(ROT_54_0);
                2'd1:    r = 4'(ROT_54_1);
                2'd2:    r = 4'(ROT_54_2);
                default: r = 4'(ROT_54_3);
            endcase
        end else begin
            case (s)
                2'd0:    r = 4'(ROT_45_0);
                2'd1:    r = 4'(ROT_45_1);
                2'd2:    r = 4'(ROT_45_2);
                default: r = 4'(ROT_45_3);
            endcase
        end
        return r;
    endfunction

    logic [NUM_ACS-1:0] req;
    logic               any_req;

    logic [1:0]  slot_q, slot_d;
    logic        valid_q, valid_d;
    logic [4:0]  tilt_q, tilt_d;
    logic        parity_q, parity_d;
    logic [4:0]  angle_q, angle_d;
    logic        overrun_q, overrun_d;
    logic [3:0]  rot;
    logic [5:0]  rot_sum;
    logic [5:0]  rot_neg;

    norm_state_e state_q, state_d;
    logic [3:0]  hold_q, hold_d;
    logic        norm_q, norm_d;
    logic [7:0]  count_q, count_d;

    assign req     = bus.normReq;
    assign any_req = |req;

    // Slot schedule, tilt/parity and the angle for the slot being presented next.
    always_comb begin
        slot_d    = slot_q;
        valid_d   = valid_q;
        tilt_d    = tilt_q;
        parity_d  = parity_q;
        overrun_d = overrun_q;
        angle_d   = '0;
        if (!bus.enable) begin
            slot_d    = '0;
            valid_d   = 1'b0;
            tilt_d    = '0;
            parity_d  = 1'b0;
            overrun_d = 1'b0;
        end else if (bus.symEn) begin
            slot_d   = '0;
            valid_d  = 1'b1;
            tilt_d   = tilt_q + TiltInc;
            parity_d = bus.symEnEven;
            // A new symbol before slot 3 cuts the previous schedule short.
            if (valid_q && (slot_q != 2'd3)) begin
                overrun_d = 1'b1;
            end
        end else if (valid_q) begin
            if (slot_q != 2'd3) begin
                slot_d = slot_q + 2'd1;
            end else begin
                valid_d = 1'b0;
            end
        end
        // Angle is built from next-state values so it lines up with the slot it accompanies.
        rot     = rot_sel(parity_d, slot_d);
        rot_sum = {1'b0, tilt_d} + {1'b0, rot, 1'b0};
        rot_neg = 6'd32 - rot_sum;
        if (bus.enable) begin
            angle_d = rot_neg[4:0];
        end
    end

    // Normalize arbitration: sample on a symbol, issue for the next full symbol, then hold off.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        norm_d  = norm_q;
        count_d = count_q;
        if (!bus.enable) begin
            state_d = StIdle;
            hold_d  = '0;
            norm_d  = 1'b0;
        end else if (bus.symEn) begin
            unique case (state_q)
                StIdle: begin
                    if (any_req) begin
                        state_d = StArmed;
                    end
                end
                StArmed: begin
                    norm_d  = 1'b1;
                    state_d = StIssue;
                end
                StIssue: begin
                    norm_d = 1'b0;
                    if (count_q != 8'hff) begin
                        count_d = count_q + 8'd1;
                    end
                    if (HoldLoad == 4'd0) begin
                        state_d = StIdle;
                    end else begin
                        hold_d  = HoldLoad;
                        state_d = StHoldoff;
                    end
                end
                StHoldoff: begin
                    if (hold_q != 4'd0) begin
                        hold_d = hold_q - 4'd1;
                    end
                    if (hold_q <= 4'd1) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State registers; reset clears everything including the normalize count.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q    <= '0;
            valid_q   <= 1'b0;
            tilt_q    <= '0;
            parity_q  <= 1'b0;
            angle_q   <= '0;
            overrun_q <= 1'b0;
            state_q   <= StIdle;
            hold_q    <= '0;
            norm_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            slot_q    <= slot_d;
            valid_q   <= valid_d;
            tilt_q    <= tilt_d;
            parity_q  <= parity_d;
            angle_q   <= angle_d;
            overrun_q <= overrun_d;
            state_q   <= state_d;
            hold_q    <= hold_d;
            norm_q    <= norm_d;
            count_q   <= count_d;
        end
    end

    assign bus.slot      = slot_q;
    assign bus.slotValid = valid_q;
    assign bus.angle     = angle_q;
    assign bus.tilt      = tilt_q;
    assign bus.parity    = parity_q;
    assign bus.normalize = norm_q;
    assign bus.normCount = count_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_acs_sched_ctrl.sv
// Scoreboard bench for acs_sched_ctrl: stimulus queues expected slot records and
// normalize edge times, monitors pop and compare as the DUT presents them.
module tb_acs_sched_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    acs_sched_ctrl_if #(.NUM_ACS(8)) bus ();

    acs_sched_ctrl #(
        .NUM_ACS(8), .TILT_STEP(1), .HOLDOFF_SYMS(2),
        .ROT_45_0(15), .ROT_45_1(3), .ROT_45_2(5), .ROT_45_3(0),
        .ROT_54_0(7), .ROT_54_1(3), .ROT_54_2(0), .ROT_54_3(9)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int rot45[4] = '{15, 3, 5, 0};
    int rot54[4] = '{7, 3, 0, 9};

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tilt_m = 0;
    bit par_m = 1'b0;
    logic prev_norm = 1'b0;
    logic [12:0] slot_exp_q[$];
    int rise_q[$];
    int fall_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int exp_angle(input int t, input int r);
        int v;
        v = 32 - t - 2 * r;
        return ((v % 32) + 32) % 32;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        tilt_m = 0;
        par_m = 1'b0;
    endtask

    // Issue one symbol strobe; ns is how many slots will be seen before the next event.
    task automatic sym(input bit even, input int ns);
        int r;
        tilt_m = (tilt_m + 1) % 32;
        par_m = even;
        for (int s = 0; s < ns && s < 4; s++) begin
            r = par_m ? rot54[s] : rot45[s];
            slot_exp_q.push_back({2'(s), 5'(exp_angle(tilt_m, r)), 5'(tilt_m), par_m});
        end
        bus.symEn = 1'b1;
        bus.symEnEven = even;
        step();
        bus.symEn = 1'b0;
        bus.symEnEven = 1'b0;
    endtask

    // Slot monitor and normalize edge monitor.
    always @(negedge clk) begin
        logic [12:0] exp_rec;
        logic [12:0] act_rec;
        if (bus.slotValid === 1'b1) begin
            act_rec = {bus.slot, bus.angle, bus.tilt, bus.parity};
            checks++;
            if (slot_exp_q.size() == 0) begin
                errors++;
                $display("FAIL slot_unexpected: got slot=%0d angle=%0d tilt=%0d expected none",
                         bus.slot, bus.angle, bus.tilt);
            end else begin
                exp_rec = slot_exp_q.pop_front();
                if (act_rec !== exp_rec) begin
                    errors++;
                    $display("FAIL slot_rec: got slot=%0d angle=%0d tilt=%0d par=%0d expected slot=%0d angle=%0d tilt=%0d par=%0d (cycle %0d)",
                             act_rec[12:11], act_rec[10:6], act_rec[5:1], act_rec[0],
                             exp_rec[12:11], exp_rec[10:6], exp_rec[5:1], exp_rec[0], cyc);
                end
            end
        end
        if (bus.normalize === 1'b1 && prev_norm === 1'b0) begin
            if (rise_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL norm_rise_unexpected: got rise at cycle %0d expected none", cyc);
            end else begin
                chk("norm_rise_cycle", cyc, rise_q.pop_front());
            end
        end
        if (bus.normalize === 1'b0 && prev_norm === 1'b1) begin
            if (fall_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL norm_fall_unexpected: got fall at cycle %0d expected none", cyc);
            end else begin
                chk("norm_fall_cycle", cyc, fall_q.pop_front());
            end
        end
        prev_norm = bus.normalize;
    end

    initial begin
        #600000;
        $display("FAIL timeout: got no finish expected finish by 600000");
        $fatal(1, "timeout");
    end

    initial begin
        bus.enable = 1'b1;
        bus.symEn = 1'b0;
        bus.symEnEven = 1'b0;
        bus.normReq = '0;
        reset = 1'b1;
        idle(2);
        chk("rst_slot", int'(bus.slot), 0);
        chk("rst_slotValid", int'(bus.slotValid), 0);
        chk("rst_angle", int'(bus.angle), 0);
        chk("rst_tilt", int'(bus.tilt), 0);
        chk("rst_parity", int'(bus.parity), 0);
        chk("rst_normalize", int'(bus.normalize), 0);
        chk("rst_normCount", int'(bus.normCount), 0);
        chk("rst_overrun", int'(bus.overrun), 0);
        reset = 1'b0;
        idle(2);

        // Schedule, tilt wrap and angle corner cases at 8-cycle spacing.
        for (int i = 0; i < 34; i++) begin
            sym(1'b0, 4);
            chk("tilt_step", int'(bus.tilt), (i + 1) % 32);
            if (i == 0) begin
                idle(3);
                chk("slot3", int'(bus.slot), 3);
                chk("slot3_valid", int'(bus.slotValid), 1);
                idle(1);
                chk("valid_drop", int'(bus.slotValid), 0);
                chk("slot_hold3", int'(bus.slot), 3);
                idle(3);
            end else if (i == 1) begin
                idle(1);
                chk("angle_45_slot1", int'(bus.angle), 24);
                idle(6);
            end else if (i == 30) begin
                chk("angle_tilt31_slot0", int'(bus.angle), 3);
                idle(7);
            end else begin
                idle(7);
            end
        end

        // Even parity selects the 5/4 table.
        do_reset();
        sym(1'b1, 4);
        idle(7);
        sym(1'b1, 4);
        idle(1);
        chk("angle_54_slot1", int'(bus.angle), 24);
        chk("parity_even", int'(bus.parity), 1);
        idle(6);

        // Single request: one normalize, holdoff requests ignored.
        do_reset();
        bus.normReq = 8'h04;
        sym(1'b0, 4);
        bus.normReq = '0;
        idle(7);
        rise_q.push_back(cyc + 1);
        sym(1'b0, 4);
        chk("norm_high", int'(bus.normalize), 1);
        idle(7);
        fall_q.push_back(cyc + 1);
        sym(1'b0, 4);
        chk("norm_count_1", int'(bus.normCount), 1);
        chk("norm_low", int'(bus.normalize), 0);
        idle(7);
        bus.normReq = '1;
        sym(1'b0, 4);
        idle(7);
        sym(1'b0, 4);
        idle(7);
        bus.normReq = '0;
        repeat (3) begin
            sym(1'b0, 4);
            idle(7);
        end
        chk("norm_count_holdoff", int'(bus.normCount), 1);

        // Constant requests: one normalize per 5 symbols, count saturates.
        do_reset();
        bus.normReq = '1;
        for (int i = 0; i < 1285; i++) begin
            if (i % 5 == 1) rise_q.push_back(cyc + 1);
            if (i % 5 == 2) fall_q.push_back(cyc + 1);
            sym(1'b0, 4);
            if (i == 52) chk("norm_count_11", int'(bus.normCount), 11);
            idle(3);
        end
        bus.normReq = '0;
        chk("norm_count_sat", int'(bus.normCount), 255);

        // Overrun from a 2-cycle symbol spacing.
        do_reset();
        sym(1'b0, 2);
        chk("overrun_clear", int'(bus.overrun), 0);
        idle(1);
        sym(1'b0, 4);
        chk("overrun_set", int'(bus.overrun), 1);
        chk("overrun_restart_slot", int'(bus.slot), 0);
        idle(7);
        sym(1'b0, 4);
        idle(7);
        chk("overrun_sticky", int'(bus.overrun), 1);
        do_reset();
        chk("overrun_reset", int'(bus.overrun), 0);

        // enable low during slot 2 keeps normCount; reset during ISSUE clears it.
        do_reset();
        bus.normReq = '1;
        sym(1'b0, 4);
        idle(7);
        rise_q.push_back(cyc + 1);
        sym(1'b0, 4);
        idle(7);
        fall_q.push_back(cyc + 1);
        sym(1'b0, 4);
        idle(7);
        sym(1'b0, 3);
        idle(2);
        bus.enable = 1'b0;
        step();
        chk("en_slotValid", int'(bus.slotValid), 0);
        chk("en_tilt", int'(bus.tilt), 0);
        chk("en_normalize", int'(bus.normalize), 0);
        chk("en_normCount", int'(bus.normCount), 1);
        tilt_m = 0;
        par_m = 1'b0;
        bus.enable = 1'b1;
        idle(2);
        sym(1'b0, 4);
        idle(7);
        rise_q.push_back(cyc + 1);
        sym(1'b0, 2);
        idle(1);
        chk("issue_high", int'(bus.normalize), 1);
        fall_q.push_back(cyc + 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        tilt_m = 0;
        par_m = 1'b0;
        bus.normReq = '0;
        chk("rstiss_normalize", int'(bus.normalize), 0);
        chk("rstiss_slotValid", int'(bus.slotValid), 0);
        chk("rstiss_tilt", int'(bus.tilt), 0);
        chk("rstiss_normCount", int'(bus.normCount), 0);
        idle(4);

        chk("slot_queue_drained", slot_exp_q.size(), 0);
        chk("rise_queue_drained", rise_q.size(), 0);
        chk("fall_queue_drained", fall_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
